// File: rtl/mii_tx_framer.sv
// Transmit-side MII framer: byte stream in, preamble/SFD/data/pad/FCS nibbles out,
// followed by an enforced inter-frame gap.
module mii_tx_framer #(
    parameter int PAD_EN     = 1,
    parameter int MIN_LEN    = 60,
    parameter int IFG_CYCLES = 24
) (
    input  logic       clk,
    input  logic       SW0,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       miiO_en,
    output logic [3:0] miiO_d,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [2:0] {
        IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DROP
    } state_t;

    localparam int TW = $clog2(IFG_CYCLES + 16);
    localparam logic [TW-1:0] PRE_LAST = TW'(14);
    localparam logic [TW-1:0] FCS_LAST = TW'(7);
    // The IDLE decision cycle supplies the last idle clock of the gap.
    localparam logic [TW-1:0] IFG_LAST = TW'(IFG_CYCLES - 2);
    localparam logic [10:0]   MIN_CNT  = 11'(MIN_LEN);

    state_t        state, stateNxt;
    logic [TW-1:0] tick, tickNxt;
    logic          phase, phaseNxt;
    logic [7:0]    curByte, byteNxt;
    logic          curLast, lastNxt;
    logic [10:0]   byteCnt, cntNxt, cntInc;
    logic [31:0]   crc, crcNxt, crcByte, fcsSh;
    logic          enNxt, urNxt, busyNxt;
    logic [3:0]    dNxt;
    logic          starve;

    function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign s_ready = (state == SFD) || (state == DROP) ||
                     ((state == DATA) && phase && !curLast);
    assign starve  = s_ready && !s_valid && (state != DROP);
    assign crcByte = crcStep(crc, (state == PAD) ? 8'h00 : curByte);
    assign cntInc  = (byteCnt == 11'd2047) ? byteCnt : byteCnt + 11'd1;
    assign fcsSh   = (~crc) >> {tick[2:0], 2'b00};

    always_comb begin
        stateNxt = state;
        tickNxt  = tick;
        phaseNxt = phase;
        byteNxt  = curByte;
        lastNxt  = curLast;
        cntNxt   = byteCnt;
        crcNxt   = crc;
        enNxt    = 1'b0;
        dNxt     = 4'h0;
        urNxt    = 1'b0;
        case (state)
            IDLE: begin
                crcNxt = '1;
                cntNxt = '0;
                if (s_valid) begin
                    stateNxt = PRE;
                    tickNxt  = '0;
                end
            end
            PRE: begin
                enNxt = 1'b1;
                dNxt  = 4'h5;
                if (tick == PRE_LAST) stateNxt = SFD;
                else                  tickNxt  = tick + TW'(1);
            end
            SFD: begin
                if (starve) begin
                    urNxt    = 1'b1;
                    stateNxt = DROP;
                end else begin
                    enNxt    = 1'b1;
                    dNxt     = 4'hD;
                    byteNxt  = s_data;
                    lastNxt  = s_last;
                    phaseNxt = 1'b0;
                    stateNxt = DATA;
                end
            end
            DATA: begin
                if (!phase) begin
                    enNxt    = 1'b1;
                    dNxt     = curByte[3:0];
                    phaseNxt = 1'b1;
                end else if (starve) begin
                    urNxt    = 1'b1;
                    stateNxt = DROP;
                end else begin
                    enNxt    = 1'b1;
                    dNxt     = curByte[7:4];
                    crcNxt   = crcByte;
                    cntNxt   = cntInc;
                    phaseNxt = 1'b0;
                    if (curLast) begin
                        tickNxt  = '0;
                        stateNxt = ((PAD_EN != 0) && (cntInc < MIN_CNT)) ? PAD : FCS;
                    end else begin
                        byteNxt = s_data;
                        lastNxt = s_last;
                    end
                end
            end
            PAD: begin
                enNxt    = 1'b1;
                phaseNxt = !phase;
                if (phase) begin
                    crcNxt = crcByte;
                    cntNxt = cntInc;
                    if (cntInc >= MIN_CNT) begin
                        tickNxt  = '0;
                        stateNxt = FCS;
                    end
                end
            end
            FCS: begin
                enNxt = 1'b1;
                dNxt  = fcsSh[3:0];
                if (tick == FCS_LAST) begin
                    tickNxt  = '0;
                    stateNxt = IFG;
                end else begin
                    tickNxt = tick + TW'(1);
                end
            end
            IFG: begin
                if (tick >= IFG_LAST) stateNxt = IDLE;
                else                  tickNxt  = tick + TW'(1);
            end
            DROP: begin
                if (s_valid && s_last) begin
                    tickNxt  = '0;
                    stateNxt = IFG;
                end
            end
            default: stateNxt = IDLE;
        endcase
        busyNxt = (stateNxt != IDLE);
    end

    always_ff @(posedge clk or posedge SW0) begin
        if (SW0) begin
            state    <= IDLE;
            tick     <= '0;
            phase    <= 1'b0;
            curByte  <= '0;
            curLast  <= 1'b0;
            byteCnt  <= '0;
            crc      <= '1;
            miiO_en  <= 1'b0;
            miiO_d   <= '0;
            underrun <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= stateNxt;
            tick     <= tickNxt;
            phase    <= phaseNxt;
            curByte  <= byteNxt;
            curLast  <= lastNxt;
            byteCnt  <= cntNxt;
            crc      <= crcNxt;
            miiO_en  <= enNxt;
            miiO_d   <= dNxt;
            underrun <= urNxt;
            busy     <= busyNxt;
        end
    end

endmodule

// File: tb/tb_mii_tx_framer.sv
// Directed bench for mii_tx_framer: a frame-level nibble model feeds an expected
// queue that a negedge monitor checks against the MII output every cycle.
module tb_mii_tx_framer;

    localparam int MIN = 60;
    localparam int IFG = 24;

    logic       clk = 1'b0;
    logic       SW0;
    logic       sel;
    logic       s_valid, s_last;
    logic [7:0] s_data;
    logic       rdy0, en0, busy0, ur0, rdy1, en1, busy1, ur1;
    logic [3:0] d0, d1;
    logic       s_ready, miiO_en, busy, underrun;
    logic [3:0] miiO_d;

    always #5 clk = ~clk;

    mii_tx_framer #(.PAD_EN(0), .MIN_LEN(MIN), .IFG_CYCLES(IFG)) dut0 (
        .clk(clk), .SW0(SW0), .s_valid(s_valid & ~sel), .s_data(s_data), .s_last(s_last),
        .s_ready(rdy0), .miiO_en(en0), .miiO_d(d0), .busy(busy0), .underrun(ur0));

    mii_tx_framer #(.PAD_EN(1), .MIN_LEN(MIN), .IFG_CYCLES(IFG)) dut1 (
        .clk(clk), .SW0(SW0), .s_valid(s_valid & sel), .s_data(s_data), .s_last(s_last),
        .s_ready(rdy1), .miiO_en(en1), .miiO_d(d1), .busy(busy1), .underrun(ur1));

    assign s_ready  = sel ? rdy1  : rdy0;
    assign miiO_en  = sel ? en1   : en0;
    assign miiO_d   = sel ? d1    : d0;
    assign busy     = sel ? busy1 : busy0;
    assign underrun = sel ? ur1   : ur0;

    int tests = 0;
    int fails = 0;
    logic [7:0] frameBuf [0:2047];
    logic [7:0] padBuf   [0:2047];
    logic [3:0] expQ[$];
    logic [3:0] capt[$];
    int runs[$];
    int gaps[$];
    int runLen = 0, lowLen = 0, urCount = 0, readyInGap = 0;
    bit sawHigh = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reflected CRC-32 over padBuf[0..m-1], returned as the transmitted FCS value.
    function automatic logic [31:0] crcOf(input int m);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int j = 0; j < m; j++) begin
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ padBuf[j][k]) c = (c >> 1) ^ 32'hEDB88320;
                else                     c = c >> 1;
            end
        end
        return ~c;
    endfunction

    // starve: 0-based index of the byte whose accept is starved (-1 = none).
    task automatic expectFrame(input int n, input int starve);
        int m = n;
        logic [31:0] f;
        for (int j = 0; j < n; j++) padBuf[j] = frameBuf[j];
        if (sel && n < MIN) begin
            for (int j = n; j < MIN; j++) padBuf[j] = 8'h00;
            m = MIN;
        end
        for (int j = 0; j < 15; j++) expQ.push_back(4'h5);
        if (starve >= 0) begin
            if (starve > 0) begin
                expQ.push_back(4'hD);
                for (int j = 0; j < starve - 1; j++) begin
                    expQ.push_back(padBuf[j][3:0]);
                    expQ.push_back(padBuf[j][7:4]);
                end
                expQ.push_back(padBuf[starve-1][3:0]);
            end
        end else begin
            expQ.push_back(4'hD);
            for (int j = 0; j < m; j++) begin
                expQ.push_back(padBuf[j][3:0]);
                expQ.push_back(padBuf[j][7:4]);
            end
            f = crcOf(m);
            for (int k = 0; k < 8; k++) expQ.push_back(f[4*k +: 4]);
        end
    endtask

    task automatic drive(input int n, input int starve, input int abortAt);
        int i = 0;
        int cyc = 0;
        bit starved = 0;
        while (i < n) begin
            @(negedge clk);
            cyc++;
            if (cyc > 4000) begin
                check("drive_timeout", 32'(i), 32'(n));
                return;
            end
            if (abortAt >= 0 && i == abortAt) begin
                #2 SW0 = 1'b1;
                #1;
                check("async_rst_en", 32'(miiO_en), 0);
                check("async_rst_d", 32'(miiO_d), 0);
                check("async_rst_busy", 32'(busy), 0);
                check("async_rst_ready", 32'(s_ready), 0);
                expQ.delete();
                @(negedge clk);
                s_valid = 1'b0;
                s_last  = 1'b0;
                SW0     = 1'b0;
                return;
            end
            if (s_ready && i == starve && !starved) begin
                s_valid = 1'b0;
                starved = 1;
            end else begin
                s_valid = 1'b1;
                s_data  = frameBuf[i];
                s_last  = (i == n - 1);
                if (s_ready) i++;
            end
        end
    endtask

    task automatic goIdle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic waitDrain();
        int k = 0;
        while ((expQ.size() != 0 || busy) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 32'(k < 3000), 1);
        check("expQ_empty", 32'(expQ.size()), 0);
    endtask

    task automatic clearLogs();
        runs.delete();
        gaps.delete();
        capt.delete();
        urCount    = 0;
        readyInGap = 0;
        sawHigh    = 0;
    endtask

    always @(negedge clk) begin
        if (SW0) begin
            runLen = 0;
            lowLen = 0;
        end else begin
            if (miiO_en) begin
                if (lowLen > 0 && sawHigh) gaps.push_back(lowLen);
                lowLen = 0;
                runLen++;
                sawHigh = 1;
                if (expQ.size() == 0) begin
                    check("extra_nibble", 32'(miiO_d), 32'hFFFF);
                end else begin
                    check("nibble", 32'(miiO_d), 32'(expQ.pop_front()));
                    capt.push_back(miiO_d);
                end
            end else begin
                if (runLen > 0) runs.push_back(runLen);
                runLen = 0;
                lowLen++;
                check("idle_d_zero", 32'(miiO_d), 0);
                if (s_ready && sawHigh) readyInGap++;
            end
            if (underrun) urCount++;
        end
    end

    initial begin
        int k;
        logic [7:0] hdr [0:13];
        logic [3:0] fcsLit [0:7];
        SW0 = 1'b1; sel = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        #3;
        check("rst_en", 32'(miiO_en), 0);
        check("rst_d", 32'(miiO_d), 0);
        check("rst_ready", 32'(s_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_underrun", 32'(underrun), 0);
        @(negedge clk);
        SW0 = 1'b0;
        repeat (3) @(negedge clk);

        // "123456789" without padding
        clearLogs();
        for (int j = 0; j < 9; j++) frameBuf[j] = 8'h31 + 8'(j);
        for (int j = 0; j < 9; j++) padBuf[j] = frameBuf[j];
        check("model_crc_check", crcOf(9), 32'hCBF43926);
        expectFrame(9, -1);
        check("model_len_t1", 32'(expQ.size()), 42);
        s_valid = 1'b1; s_data = frameBuf[0]; s_last = 1'b0;
        @(posedge clk); #1;
        check("lat_en_low", 32'(miiO_en), 0);
        check("lat_busy", 32'(busy), 1);
        @(posedge clk); #1;
        check("lat_en_high", 32'(miiO_en), 1);
        check("lat_d5", 32'(miiO_d), 5);
        drive(9, -1, -1);
        goIdle();
        waitDrain();
        check("t1_runs", 32'(runs.size()), 1);
        if (runs.size() > 0) check("t1_len", 32'(runs[0]), 42);
        check("t1_capt", 32'(capt.size()), 42);
        if (capt.size() == 42) begin
            fcsLit = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
            check("t1_first_lo", 32'(capt[16]), 1);
            check("t1_first_hi", 32'(capt[17]), 3);
            for (int j = 0; j < 8; j++) check("t1_fcs_lit", 32'(capt[34+j]), 32'(fcsLit[j]));
        end

        // single byte, padded to MIN
        sel = 1'b1;
        repeat (2) @(negedge clk);
        clearLogs();
        frameBuf[0] = 8'hAB;
        expectFrame(1, -1);
        check("model_len_t2", 32'(expQ.size()), 144);
        drive(1, -1, -1);
        goIdle();
        waitDrain();
        if (runs.size() > 0) check("t2_len", 32'(runs[0]), 144);
        else check("t2_runs", 0, 1);

        // 49-byte header+payload frame, padded to 60
        clearLogs();
        hdr = '{8'h54, 8'hFF, 8'h01, 8'h21, 8'h23, 8'h24,
                8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h12, 8'h34};
        for (int j = 0; j < 14; j++) frameBuf[j] = hdr[j];
        for (int j = 14; j < 49; j++) frameBuf[j] = 8'h40 + 8'(j);
        expectFrame(49, -1);
        drive(49, -1, -1);
        goIdle();
        waitDrain();
        if (runs.size() > 0) check("t3_len", 32'(runs[0]), 144);
        else check("t3_runs", 0, 1);
        if (capt.size() > 17) check("t3_dst0", 32'({capt[17], capt[16]}), 32'h54);

        // back-to-back frames, s_valid held through the gap
        clearLogs();
        for (int j = 0; j < 64; j++) frameBuf[j] = 8'(j * 3);
        expectFrame(64, -1);
        drive(64, -1, -1);
        for (int j = 0; j < 10; j++) frameBuf[j] = 8'hF0 - 8'(j);
        expectFrame(10, -1);
        drive(10, -1, -1);
        goIdle();
        waitDrain();
        check("b2b_gap_cnt", 32'(gaps.size()), 1);
        if (gaps.size() > 0) check("b2b_gap", 32'(gaps[0]), IFG);
        check("b2b_ready_in_gap", 32'(readyInGap), 0);
        if (runs.size() == 2) begin
            check("b2b_len0", 32'(runs[0]), 16 + 128 + 8);
            check("b2b_len1", 32'(runs[1]), 144);
        end else check("b2b_runs", 32'(runs.size()), 2);

        // underrun on the 5th accept
        clearLogs();
        for (int j = 0; j < 20; j++) frameBuf[j] = 8'h80 + 8'(j);
        expectFrame(20, 4);
        drive(20, 4, -1);
        k = 0;
        goIdle();
        while (busy && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("ur_ifg_range", 32'(k >= IFG - 1 && k <= IFG), 1);
        waitDrain();
        check("ur_pulse", 32'(urCount), 1);
        if (runs.size() > 0) check("ur_len", 32'(runs[0]), 23);
        else check("ur_runs", 0, 1);

        // reset mid-DATA, then a clean frame
        clearLogs();
        for (int j = 0; j < 30; j++) frameBuf[j] = 8'h11 * 8'(j % 15);
        expectFrame(30, -1);
        drive(30, -1, 6);
        repeat (3) @(negedge clk);
        clearLogs();
        for (int j = 0; j < 30; j++) frameBuf[j] = 8'hC3 ^ 8'(j);
        expectFrame(30, -1);
        drive(30, -1, -1);
        goIdle();
        waitDrain();
        if (runs.size() > 0) check("rst_frame_len", 32'(runs[0]), 144);
        else check("rst_frame_runs", 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
